// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//
// Purpose:
//   Watches a time-multiplexed, active-low 7-segment display bus and rebuilds
//   the BCD value of every digit. A digit is captured once its sampled
//   {anode, segment} pattern has stayed identical for STABLE_CYCLES
//   consecutive samples. A one-cycle frame strobe marks the point where every
//   digit has been refreshed at least once since the previous strobe.
//
// Parameters:
//   DIGITS        number of multiplexed digits / anodes (1..8)
//   STABLE_CYCLES consecutive identical samples required before capture (>=1)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   seg_n        segment lines, active-low, bit 6 = a ... bit 0 = g
//   an_n         digit anodes, active-low, bit i selects digit i
//   digits       captured BCD values, digit i at [4i+3:4i]
//   digit_err    bit i set when digit i's last capture was an illegal pattern
//   frame_valid  one-cycle pulse when all digits have been captured
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid
);

    localparam int            CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
    localparam bit            ONE_SHOT   = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        BLANK,
        SETTLE,
        HELD
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DIGITS-1:0]   seen;

    // Sample register and the sample one edge older, used for stability checks.
    logic [DIGITS-1:0]   s_an;
    logic [6:0]          s_seg;
    logic [DIGITS-1:0]   prev_an;
    logic [6:0]          prev_seg;

    logic [DIGITS-1:0]   sel;
    logic                valid;
    logic                same;
    logic [CW-1:0]       cnt_inc;
    logic                take;
    logic [3:0]          dec_val;
    logic                dec_err;
    logic [DIGITS-1:0]   seen_upd;

    // Selection qualification: exactly one anode low. The one-hot test uses
    // the x & (x-1) trick on the inverted anode word.
    always_comb begin
        sel     = ~s_an;
        valid   = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
        same    = (s_an == prev_an) && (s_seg == prev_seg);
        cnt_inc = cnt + CW'(1);
    end

    // Capture decision. A capture is taken when the dwell count reaches
    // STABLE_CYCLES; with a one-sample dwell, every new valid selection
    // captures immediately, whatever state it arrives in.
    always_comb begin
        take = 1'b0;
        if (valid) begin
            case (state)
                BLANK:   take = ONE_SHOT;
                SETTLE:  take = same ? (cnt_inc == STABLE_MAX) : ONE_SHOT;
                HELD:    take = !same && ONE_SHOT;
                default: take = 1'b0;
            endcase
        end
    end

    // Segment decode of the sampled pattern. A fully dark digit is a legal
    // blank (F, no error); anything outside the table is flagged.
    always_comb begin
        dec_val = 4'hF;
        dec_err = 1'b0;
        case (s_seg)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0001100: dec_val = 4'd9;
            7'b1111111: dec_val = 4'hF;
            default: begin
                dec_val = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        seen_upd = seen | sel;
    end

    // Sampling, dwell FSM, capture and frame tracking. The FSM acts on the
    // sample taken at the previous edge, so a bus change arriving on the
    // capture edge only lands in the sample register and cannot cancel it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_an        <= '1;
            s_seg       <= '1;
            prev_an     <= '1;
            prev_seg    <= '1;
            state       <= BLANK;
            cnt         <= '0;
            seen        <= '0;
            digits      <= '1;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            s_an        <= an_n;
            s_seg       <= seg_n;
            prev_an     <= s_an;
            prev_seg    <= s_seg;
            frame_valid <= 1'b0;

            case (state)
                BLANK: begin
                    cnt <= '0;
                    if (valid) begin
                        cnt   <= CW'(1);
                        state <= ONE_SHOT ? HELD : SETTLE;
                    end
                end
                SETTLE: begin
                    if (!valid) begin
                        cnt   <= '0;
                        state <= BLANK;
                    end else if (same) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == STABLE_MAX) begin
                            state <= HELD;
                        end
                    end else begin
                        cnt   <= CW'(1);
                        state <= ONE_SHOT ? HELD : SETTLE;
                    end
                end
                HELD: begin
                    if (!valid) begin
                        cnt   <= '0;
                        state <= BLANK;
                    end else if (!same) begin
                        cnt   <= CW'(1);
                        state <= ONE_SHOT ? HELD : SETTLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= BLANK;
                end
            endcase

            if (take) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i]) begin
                        digits[4*i +: 4] <= dec_val;
                        digit_err[i]     <= dec_err;
                    end
                end
                // The completing capture closes the current frame, so seen
                // restarts empty rather than holding this digit's bit.
                if (&seen_upd) begin
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seen_upd;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Self-checking bench for seg_scan_decoder (DIGITS=4, STABLE_CYCLES=4).
// A reference model tracks how long each valid bus pattern has been seen
// and captures once per uninterrupted run that reaches the dwell length.
// Directed scenarios are followed by a randomized scan.
// ---------------------------------------------------------------------------
module tb_seg_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic                 clk;
    logic                 rst_n;
    logic [6:0]           seg_n;
    logic [DIGITS-1:0]    an_n;
    logic [4*DIGITS-1:0]  digits;
    logic [DIGITS-1:0]    digit_err;
    logic                 frame_valid;

    int total;
    int bad;
    int pulses;
    logic [4*DIGITS-1:0] pulse_digits;

    // Reference model state.
    logic [DIGITS-1:0]   m_samp_an;
    logic [6:0]          m_samp_seg;
    logic [DIGITS-1:0]   m_last_an;
    logic [6:0]          m_last_seg;
    int                  m_run;
    bit                  m_taken;
    logic [4*DIGITS-1:0] m_digits;
    logic [DIGITS-1:0]   m_err;
    logic [DIGITS-1:0]   m_seen;
    logic                m_fv;

    logic [6:0] pats [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0001100};

    seg_scan_decoder #(
        .DIGITS(DIGITS),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_n(seg_n),
        .an_n(an_n),
        .digits(digits),
        .digit_err(digit_err),
        .frame_valid(frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {err, value} for a segment pattern, straight from the display table.
    function automatic logic [4:0] decodeRef(input logic [6:0] s);
        logic [4:0] r;
        r = {1'b1, 4'hF};
        if (s == 7'b1111111) r = {1'b0, 4'hF};
        for (int d = 0; d < 10; d++) begin
            if (s == pats[d]) r = {1'b0, 4'(d)};
        end
        return r;
    endfunction

    // Model update for one rising edge, using the inputs presented at it.
    task automatic modelEdge();
        int idx;
        logic [4:0] dv;
        if (!rst_n) begin
            m_samp_an  = '1;
            m_samp_seg = '1;
            m_last_an  = '1;
            m_last_seg = '1;
            m_run      = 0;
            m_taken    = 1'b0;
            m_digits   = '1;
            m_err      = '0;
            m_seen     = '0;
            m_fv       = 1'b0;
        end else begin
            m_fv = 1'b0;
            if ($countones(~m_samp_an) == 1) begin
                if (m_run > 0 && m_samp_an == m_last_an && m_samp_seg == m_last_seg) begin
                    m_run++;
                end else begin
                    m_run   = 1;
                    m_taken = 1'b0;
                end
                if (!m_taken && m_run >= STABLE) begin
                    m_taken = 1'b1;
                    idx = 0;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (!m_samp_an[i]) idx = i;
                    end
                    dv = decodeRef(m_samp_seg);
                    m_digits[4*idx +: 4] = dv[3:0];
                    m_err[idx]  = dv[4];
                    m_seen[idx] = 1'b1;
                    if (m_seen == '1) begin
                        m_fv   = 1'b1;
                        m_seen = '0;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_last_an  = m_samp_an;
            m_last_seg = m_samp_seg;
            m_samp_an  = an_n;
            m_samp_seg = seg_n;
        end
    endtask

    // One clock edge: advance the model, then compare #1 after the edge.
    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("digits", 32'(digits), 32'(m_digits));
        checkOutput("digit_err", 32'(digit_err), 32'(m_err));
        checkOutput("frame_valid", 32'(frame_valid), 32'(m_fv));
        if (frame_valid === 1'b1) begin
            pulses++;
            pulse_digits = digits;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [DIGITS-1:0] an,
                                 input logic [6:0] seg, input int n);
        rst_n = rst;
        an_n  = an;
        seg_n = seg;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic scanDigits(input int v0, input int v1, input int v2, input int v3);
        int vals [4];
        vals = '{v0, v1, v2, v3};
        for (int d = 0; d < 4; d++) begin
            applyStimulus(1'b1, ~(4'(1) << d), pats[vals[d]], 6);
            applyStimulus(1'b1, 4'b1111, 7'b1111111, 2);
        end
    endtask

    initial begin
        int kind;
        int dig;
        int dwell;
        int a;
        int b;
        logic [6:0] seg;
        logic [DIGITS-1:0] an;

        total  = 0;
        bad    = 0;
        pulses = 0;
        pulse_digits = '0;
        rst_n = 1'b0;
        an_n  = '1;
        seg_n = '1;

        // Reset with random bus activity, then an idle bus.
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, 4'($urandom), 7'($urandom), 1);
        checkOutput("reset_digits", 32'(digits), 32'h0000FFFF);
        checkOutput("reset_err", 32'(digit_err), 32'h0);
        checkOutput("reset_fv", 32'(frame_valid), 32'h0);
        applyStimulus(1'b1, 4'b1111, 7'b1111111, 20);
        checkOutput("idle_digits", 32'(digits), 32'h0000FFFF);

        // Single capture: value 3 appears on edge 4, not earlier.
        applyStimulus(1'b1, 4'b1110, 7'b0000110, 4);
        checkOutput("single_early", 32'(digits[3:0]), 32'hF);
        step();
        checkOutput("single_val", 32'(digits[3:0]), 32'h3);
        checkOutput("single_err", 32'(digit_err[0]), 32'h0);
        applyStimulus(1'b1, 4'b1111, 7'b1111111, 2);
        checkOutput("single_nopulse", 32'(pulses), 32'h0);

        // Glitch at edge 2 restarts the dwell; capture lands at edge 7.
        applyStimulus(1'b0, 4'b1111, 7'b1111111, 2);
        applyStimulus(1'b1, 4'b1110, 7'b0000110, 2);
        applyStimulus(1'b1, 4'b1110, 7'b1001111, 1);
        applyStimulus(1'b1, 4'b1110, 7'b0000110, 4);
        checkOutput("glitch_early", 32'(digits[3:0]), 32'hF);
        step();
        checkOutput("glitch_val", 32'(digits[3:0]), 32'h3);
        applyStimulus(1'b1, 4'b1111, 7'b1111111, 2);

        // Full frame scans.
        applyStimulus(1'b0, 4'b1111, 7'b1111111, 2);
        pulses = 0;
        scanDigits(1, 9, 0, 5);
        checkOutput("frame1_pulses", 32'(pulses), 32'h1);
        checkOutput("frame1_digits", 32'(pulse_digits), 32'h00005091);
        scanDigits(1, 9, 0, 5);
        checkOutput("frame2_pulses", 32'(pulses), 32'h2);

        // Illegal, blank, then legal pattern on digit 1.
        applyStimulus(1'b1, 4'b1101, 7'b1111110, 6);
        checkOutput("illegal_val", 32'(digits[7:4]), 32'hF);
        checkOutput("illegal_err", 32'(digit_err[1]), 32'h1);
        applyStimulus(1'b1, 4'b1111, 7'b1111111, 2);
        applyStimulus(1'b1, 4'b1101, 7'b1111111, 6);
        checkOutput("blank_val", 32'(digits[7:4]), 32'hF);
        checkOutput("blank_err", 32'(digit_err[1]), 32'h0);
        applyStimulus(1'b1, 4'b1111, 7'b1111111, 2);
        applyStimulus(1'b1, 4'b1101, 7'b0010010, 6);
        checkOutput("two_val", 32'(digits[7:4]), 32'h2);
        checkOutput("two_err", 32'(digit_err[1]), 32'h0);
        applyStimulus(1'b1, 4'b1111, 7'b1111111, 2);

        // Multi-anode selection is blanking; then reset mid-dwell.
        applyStimulus(1'b1, 4'b1100, 7'b0001111, 10);
        checkOutput("multi_digit2", 32'(digits[11:8]), 32'h0);
        applyStimulus(1'b1, 4'b1011, 7'b0001111, 2);
        applyStimulus(1'b0, 4'b1011, 7'b0001111, 1);
        checkOutput("midreset_digits", 32'(digits), 32'h0000FFFF);
        checkOutput("midreset_err", 32'(digit_err), 32'h0);
        checkOutput("midreset_fv", 32'(frame_valid), 32'h0);
        applyStimulus(1'b1, 4'b1011, 7'b0001111, 4);
        checkOutput("midreset_early", 32'(digits[11:8]), 32'hF);
        step();
        checkOutput("midreset_capture", 32'(digits[11:8]), 32'h7);

        // Randomized scanning against the model.
        for (int n = 0; n < 300; n++) begin
            kind  = $urandom_range(0, 19);
            dwell = $urandom_range(1, 7);
            if (kind == 0) begin
                applyStimulus(1'b0, 4'($urandom), 7'($urandom), 1);
            end else if (kind <= 2) begin
                a  = $urandom_range(0, 3);
                b  = (a + $urandom_range(1, 3)) % 4;
                an = 4'b1111 & ~(4'(1) << a) & ~(4'(1) << b);
                applyStimulus(1'b1, an, 7'($urandom), dwell);
            end else if (kind <= 4) begin
                applyStimulus(1'b1, 4'b1111, 7'($urandom), dwell);
            end else begin
                dig = $urandom_range(0, 3);
                a   = $urandom_range(0, 9);
                b   = $urandom_range(0, 9);
                if (b == 0)      seg = 7'b1111111;
                else if (b <= 2) seg = 7'($urandom);
                else             seg = pats[a];
                applyStimulus(1'b1, ~(4'(1) << dig), seg, dwell);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the team's BCD-to-7-segment encoder. It watches a time-multiplexed, active-low 7-segment display bus (segment lines plus digit anodes) and rebuilds the BCD value of each digit. Each digit is captured only after its pattern has been stable for a programmable dwell. A one-cycle frame strobe marks the point where every digit has been refreshed. It sits on the display-bus tap in test and loopback builds and checks what the display driver actually emits.

## Interface
- DIGITS, default 4: number of multiplexed digits (anodes); 1..8.
- STABLE_CYCLES, default 4: consecutive identical samples required before capture; ≥1.

- clk  input  1  rising-edge clock; only clock in the block.
- rst_n  input  1  reset, synchronous, active-low.
- seg_n  input  7  segment lines, active-low, bit 6 = a … bit 0 = g; same clock domain.
- an_n  input  DIGITS  digit anodes, active-low; bit i selects digit i.
- digits  output  4*DIGITS  captured BCD values; digit i at [4i+3:4i].
- digit_err  output  DIGITS  bit i set when digit i's last capture was an illegal pattern.
- frame_valid  output  1  one-cycle pulse when all DIGITS digits have been captured since the previous pulse or reset.

## Operation
- Every edge, seg_n and an_n are registered into a sample register, giving {s_an, s_seg}.
- An anode word is a valid selection only when exactly one bit of s_an is 0. Any other value is blanking.
- The FSM has three states: BLANK, SETTLE and HELD.
  - BLANK: cnt=0. If the sample is a valid selection, go to SETTLE with cnt=1.
  - SETTLE: if the sample equals the previous sample, cnt increments. If the sample changes to another valid selection, cnt=1 and the state stays SETTLE. If the sample goes to blanking, go to BLANK. When cnt reaches STABLE_CYCLES, capture and go to HELD.
  - HELD: cnt is frozen and no further capture is taken. A change to another valid selection goes to SETTLE with cnt=1. Blanking goes to BLANK.
- With STABLE_CYCLES=1, a capture is taken on the first sampled cycle of each new valid selection.
- Capture decodes s_seg. Target is the digit i whose anode bit is 0. Decode table:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0001100=9
  - 1111111 (blank) gives digit=4'hF with err=0.
  - Any other pattern gives digit=4'hF with err=1.
- Each capture sets seen[i]. Seen bits are cumulative; recapturing a digit already seen in the current frame overwrites its value but does not advance the frame.
- When a capture makes seen all-ones:
  - frame_valid=1 for exactly one cycle.
  - seen clears to 0 at the same edge.
  - The completing capture belongs to the finished frame, not the next one.
- cnt width is clog2(STABLE_CYCLES+1) and cnt never wraps.

## Timing
- Reset values, applied at the first rising edge with rst_n=0:
  - digits all ones; digit_err=0; frame_valid=0.
  - seen=0, cnt=0, state BLANK, sample register cleared to all ones (blank).
- Capture latency:
  - A pattern present at the input for edges 0..STABLE_CYCLES-1 produces an update of digits/digit_err at edge STABLE_CYCLES.
  - A change presented at edge STABLE_CYCLES does not cancel that capture.
- frame_valid is registered at the same edge as the completing digits update and deasserts at the next edge.
- Boundary conditions:
  - A glitch of one sample restarts the count; no partial capture is taken.
  - Two or more anodes low: treated as blanking, no capture.
  - The same digit re-entered after blanking is captured again; its seen bit is already set.
  - rst_n low mid-dwell abandons the dwell. Outputs return to reset values at that edge. Counting restarts from BLANK after release.

## Test plan
1. Reset check: hold rst_n=0 for 2 cycles with random bus activity. Required: digits=16'hFFFF, digit_err=0, frame_valid=0. After release with the bus idle (an_n all ones), nothing changes for 20 cycles.
2. Single capture: STABLE_CYCLES=4, drive an_n=4'b1110, seg_n=7'b0000110 from edge 0. Required: digits[3:0]=3 at edge 4 and not before; digit_err[0]=0; no frame_valid.
3. Glitch: same stimulus as scenario 2, but seg_n=7'b1001111 for one cycle at edge 2, then 7'b0000110 again. Required: no capture of either value before edge 7; digit 0 is 3 at edge 7.
4. Full frame: scan digits 0..3 with patterns 1, 9, 0, 5, each dwelling 6 cycles and separated by 2 blank cycles. Required: one frame_valid pulse, coincident with digits=16'h5091. A second identical scan produces exactly one more pulse.
5. Illegal and blank patterns:
   - digit 1 with 7'b1111110. Required: digits[7:4]=F, digit_err[1]=1.
   - Then digit 1 with 7'b1111111. Required: F, digit_err[1]=0.
   - Then 7'b0010010. Required: 2, digit_err[1]=0.
6. Multi-anode and reset: drive an_n=4'b1100 for 10 cycles. Required: no update. Then start a valid dwell and pulse rst_n low at edge 2. Required: no capture, all outputs at reset values, and the next full dwell captures normally.
